// File: rtl/exe_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | exe_stage_pkg                                                        |
// | Shared encodings and helpers for the execute stage.                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package exe_stage_pkg;

    localparam logic [3:0] c_exe_mov = 4'b0001;
    localparam logic [3:0] c_exe_add = 4'b0010;
    localparam logic [3:0] c_exe_adc = 4'b0011;
    localparam logic [3:0] c_exe_sub = 4'b0100;
    localparam logic [3:0] c_exe_sbc = 4'b0101;
    localparam logic [3:0] c_exe_and = 4'b0110;
    localparam logic [3:0] c_exe_orr = 4'b0111;
    localparam logic [3:0] c_exe_eor = 4'b1000;
    localparam logic [3:0] c_exe_mvn = 4'b1001;

    localparam logic [1:0] c_sh_lsl = 2'b00;
    localparam logic [1:0] c_sh_lsr = 2'b01;
    localparam logic [1:0] c_sh_asr = 2'b10;
    localparam logic [1:0] c_sh_ror = 2'b11;

    localparam logic [1:0] c_fwd_reg = 2'b00;
    localparam logic [1:0] c_fwd_mem = 2'b01;
    localparam logic [1:0] c_fwd_wb  = 2'b10;

    // Code 11 is unused by the hazard unit and falls back to the register value.
    function automatic logic [31:0] fwd_select(
        input logic [1:0]  sel,
        input logic [31:0] reg_val,
        input logic [31:0] mem_val,
        input logic [31:0] wb_val
    );
        logic [31:0] r;
        case (sel)
            c_fwd_mem: r = mem_val;
            c_fwd_wb:  r = wb_val;
            default:   r = reg_val;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] amt);
        logic [63:0] d;
        d = {x, x} >> amt;
        return d[31:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/val2_generator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | val2_generator                                                       |
// | Second ALU operand: memory offset, rotated immediate or shifted Rm.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module val2_generator
    import exe_stage_pkg::*;
(
    input  logic        mem_en,
    input  logic        imm,
    input  logic [11:0] shift_operand,
    input  logic [31:0] rm,
    output logic [31:0] val2
);

    logic [31:0] w_imm_word;
    logic [4:0]  w_imm_rot;
    logic [4:0]  w_sh_amt;
    logic [1:0]  w_sh_type;
    logic [31:0] w_rot_imm;
    logic [31:0] w_shifted;

    assign w_imm_word = {24'b0, shift_operand[7:0]};
    assign w_imm_rot  = {shift_operand[11:8], 1'b0};
    assign w_sh_amt   = shift_operand[11:7];
    assign w_sh_type  = shift_operand[6:5];
    assign w_rot_imm  = ror32(w_imm_word, w_imm_rot);

    // Amount 0 passes Rm through for every type, unlike the ARM LSR/ASR #32 encoding.
    always_comb begin
        w_shifted = rm;
        case (w_sh_type)
            c_sh_lsl: w_shifted = rm << w_sh_amt;
            c_sh_lsr: w_shifted = rm >> w_sh_amt;
            c_sh_asr: w_shifted = $unsigned($signed(rm) >>> w_sh_amt);
            c_sh_ror: w_shifted = ror32(rm, w_sh_amt);
            default:  w_shifted = rm;
        endcase
    end

    always_comb begin
        val2 = w_shifted;
        if (mem_en) begin
            val2 = {20'b0, shift_operand};
        end else if (imm) begin
            val2 = w_rot_imm;
        end
    end

endmodule
`default_nettype wire

// File: rtl/exe_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | exe_stage                                                            |
// | Execute stage: forwarding, Val2, ALU, NZCV status and branch target. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic [31:0] val_rn_in,
    input  logic [31:0] val_rm_in,
    input  logic [3:0]  exe_cmd_in,
    input  logic        imm_in,
    input  logic [11:0] shift_operand_in,
    input  logic [23:0] signed_imm_24_in,
    input  logic        mem_r_en_in,
    input  logic        mem_w_en_in,
    input  logic        b_in,
    input  logic        s_in,
    input  logic [1:0]  sel_src1,
    input  logic [1:0]  sel_src2,
    input  logic [31:0] alu_res_mem,
    input  logic [31:0] wb_value,
    output logic [31:0] alu_res,
    output logic [31:0] st_val,
    output logic        branch_taken,
    output logic [31:0] branch_addr,
    output logic [3:0]  status_out
);

    logic [3:0]  r_status;
    logic [31:0] w_op_a;
    logic [31:0] w_rm;
    logic [31:0] w_val2;
    logic [31:0] w_op_b;
    logic        w_cin;
    logic        w_arith;
    logic        w_valid;
    logic [32:0] w_sum;
    logic [31:0] w_res;
    logic        w_c;
    logic        w_v;
    logic [3:0]  w_nzcv;

    assign w_op_a = fwd_select(sel_src1, val_rn_in, alu_res_mem, wb_value);
    assign w_rm   = fwd_select(sel_src2, val_rm_in, alu_res_mem, wb_value);

    val2_generator u_val2 (
        .mem_en        (mem_r_en_in | mem_w_en_in),
        .imm           (imm_in),
        .shift_operand (shift_operand_in),
        .rm            (w_rm),
        .val2          (w_val2)
    );

    // Subtraction is A + ~B + cin so one adder yields NOT-borrow as carry-out.
    always_comb begin
        w_op_b  = w_val2;
        w_cin   = 1'b0;
        w_arith = 1'b0;
        case (exe_cmd_in)
            c_exe_add: w_arith = 1'b1;
            c_exe_adc: begin
                w_arith = 1'b1;
                w_cin   = r_status[1];
            end
            c_exe_sub: begin
                w_arith = 1'b1;
                w_op_b  = ~w_val2;
                w_cin   = 1'b1;
            end
            c_exe_sbc: begin
                w_arith = 1'b1;
                w_op_b  = ~w_val2;
                w_cin   = r_status[1];
            end
            default: ;
        endcase
    end

    assign w_sum = {1'b0, w_op_a} + {1'b0, w_op_b} + {32'b0, w_cin};

    always_comb begin
        w_res   = '0;
        w_c     = r_status[1];
        w_v     = r_status[0];
        w_valid = 1'b1;
        case (exe_cmd_in)
            c_exe_mov: w_res = w_val2;
            c_exe_mvn: w_res = ~w_val2;
            c_exe_and: w_res = w_op_a & w_val2;
            c_exe_orr: w_res = w_op_a | w_val2;
            c_exe_eor: w_res = w_op_a ^ w_val2;
            c_exe_add, c_exe_adc, c_exe_sub, c_exe_sbc: w_res = w_sum[31:0];
            default: w_valid = 1'b0;
        endcase
        if (w_arith) begin
            w_c = w_sum[32];
            w_v = (w_op_a[31] == w_op_b[31]) && (w_sum[31] != w_op_a[31]);
        end
    end

    assign w_nzcv = w_valid ? {w_res[31], (w_res == 32'd0), w_c, w_v} : 4'b0000;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_status <= 4'b0000;
        end else if (s_in) begin
            r_status <= w_nzcv;
        end
    end

    assign alu_res      = w_res;
    assign st_val       = w_rm;
    assign branch_taken = b_in;
    assign branch_addr  = pc_in + {{6{signed_imm_24_in[23]}}, signed_imm_24_in, 2'b00};
    assign status_out   = r_status;

endmodule
`default_nettype wire

// File: doc/exe_stage.md
EXE_STAGE -- requirements
Module: exe_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; its ports SHALL be named clk and rst.
REQ-002 The clock port SHALL be: clk  in  1  rising-edge clock.
REQ-003 The reset port SHALL be: rst  in  1  synchronous, active-low reset.
REQ-004 The block SHALL have these input ports:
- pc_in  in  32  PC+4 of the instruction.
- val_rn_in, val_rm_in  in  32  register operands from the ID/EX register.
- exe_cmd_in  in  4  ALU command.
- imm_in  in  1  immediate operand select.
- shift_operand_in  in  12  shifter operand field.
- signed_imm_24_in  in  24  branch offset.
- mem_r_en_in, mem_w_en_in, b_in, s_in  in  1  load, store, branch and set-flags controls.
- sel_src1, sel_src2  in  2  forwarding selects: 00 = register, 01 = alu_res_mem, 10 = wb_value.
- alu_res_mem, wb_value  in  32  forwarded values.
REQ-005 The block SHALL have these output ports:
- alu_res  out  32  ALU result or memory address.
- st_val  out  32  forwarded Rm, used as store data.
- branch_taken  out  1  equals b_in.
- branch_addr  out  32  branch target.
- status_out  out  4  registered NZCV, with N in bit 3, used by ID condition check.

Function
REQ-006 Operand A SHALL be val_rn_in, alu_res_mem or wb_value, chosen by sel_src1; Rm SHALL be chosen the same way by sel_src2; sel = 11 SHALL select the register value.
REQ-007 Val2 SHALL be generated as follows, with the first matching rule applied:
- If mem_r_en_in or mem_w_en_in: zero-extended shift_operand_in[11:0].
- Else if imm_in: {24'b0, shift_operand_in[7:0]} rotated right by 2*shift_operand_in[11:8].
- Else: Rm shifted by shift_operand_in[11:7], with shift_operand_in[6:5] selecting 00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-008 A shift or rotate amount of 0 SHALL pass the operand through unchanged, for every shift type.
REQ-009 The ALU SHALL compute, with C the registered carry:
- 0001 MOV: Val2.
- 1001 MVN: ~Val2.
- 0010 ADD: A+Val2.
- 0011 ADC: A+Val2+C.
- 0100 SUB: A-Val2.
- 0101 SBC: A-Val2-!C.
- 0110 AND.
- 0111 ORR.
- 1000 EOR.
- Any other code: result 0, with all flags 0.
REQ-010 Flags SHALL be computed as follows:
- N = result[31].
- Z = (result == 0).
- C = carry-out for ADD/ADC.
- C = NOT borrow for SUB/SBC.
- V = signed overflow for add/sub.
- For logical ops and MOV/MVN, C and V SHALL keep their registered values.
REQ-011 alu_res, st_val, branch_addr and branch_taken SHALL be combinational, with zero-cycle latency.
REQ-012 branch_addr SHALL equal pc_in + (sign-extended signed_imm_24_in << 2), computed modulo 2^32.
REQ-013 The status register SHALL load the ALU NZCV on the rising clk edge when s_in = 1, and SHALL hold otherwise.
REQ-014 status_out SHALL reflect the new value one cycle after the s_in cycle.
REQ-015 ADC/SBC SHALL use the pre-edge carry, including when s_in is set in the same cycle.
REQ-016 Arithmetic SHALL wrap modulo 2^32 with no saturation.
REQ-017 Because a flushed ID/EX register presents s_in = 0, a flushed cycle SHALL NOT alter status_out.

Reset
REQ-018 When rst = 0 at a rising edge, status_out SHALL become 4'b0000, and this SHALL override s_in.
REQ-019 Combinational outputs SHALL follow their inputs during reset.
REQ-020 Reset deasserted mid-stream SHALL resume normal updates at the next edge.

Structure
REQ-021 The exe_cmd encodings, the shift-type codes and the forwarding-select codes SHALL reside in the shared package.
REQ-022 Val2 generation SHALL be one sub-module, val2_generator.
REQ-023 The ALU and the status register SHALL be inline logic.

Verification
REQ-024 ADD 0x7FFFFFFF + 1 with s_in = 1 -> alu_res = 0x80000000; status_out = 1001 after one edge.
REQ-025 SUB 5 - 5 with s_in = 1 -> alu_res = 0; next-cycle status_out = 0110. Then ADC 1 + 1 -> alu_res = 3.
REQ-026 imm_in = 1 with shift_operand_in = 0x4FF -> Val2 = 0xFF000000. ROR with Rm = 0x1, amount 1 -> 0x80000000. ASR with Rm = 0x80000000, amount 4 -> 0xF8000000.
REQ-027 STR with val_rn = 0x100 and offset 0x004 -> alu_res = 0x104. With sel_src2 = 10 and wb_value = 0xAB -> st_val = 0xAB.
REQ-028 b_in = 1, pc_in = 0x20, imm24 = 0xFFFFFE -> branch_addr = 0x18 and branch_taken = 1.
REQ-029 s_in = 1 and rst = 0 on the same edge -> status_out = 0000. An s_in = 0 cycle leaves status_out unchanged.
